multicycle_controller: RTL and testbench

- Finite-state controller that sequences a shared-memory multicycle RV32I datapath (subset: lw, sw, R-type, I-type ALU, beq, jal). It reuses one ALU and one memory port across cycles.
- Drives mux selects, write enables and ALU control each cycle from the opcode, funct fields and ALU zero flag.
- Handles variable-latency memory through a mem_ready handshake, with a wait-timeout trap.
- Keeps an instruction-retired counter.

---
 rtl/mc_pkg.sv | 52 +++++
 rtl/mc_alu_decoder.sv | 30 +++
 rtl/multicycle_controller.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared states, opcodes and select encodings for the multicycle controller
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - maps alu_op and funct fields to the ALU control code
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          // funct7b5 only means sub for register-register ops; for addi it is an immediate bit
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - sequencing FSM for a shared-memory multicycle RV32I datapath
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [2:0]           alu_control,
  output logic                 reg_write,
  output logic                 illegal_instr,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] retire_count
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0]  retire_count_q, retire_count_d;
  logic                  illegal_q, illegal_d;
  logic                  timeout_q, timeout_d;

  logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c;
  logic       mem_wait;
  logic [1:0] alu_op;

  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op      = ALU_OP_ADD;
    mem_wait    = 1'b0;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
        mem_wait   = 1'b1;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_wait = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_MEMDATA;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        mem_wait    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALU_OP_SUB;
        pc_write_c = zero;
        state_d    = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase

    // A completing access on the last allowed cycle still proceeds normally
    if (mem_wait && !mem_ready && (wait_cnt_q == WAIT_LAST)) begin
      state_d   = S_TRAP;
      timeout_d = 1'b1;
    end

    wait_cnt_d = (mem_wait && !mem_ready && (state_d == state_q)) ?
                 wait_cnt_q + WAIT_W'(1) : '0;

    retire_count_d = retire_count_q;
    if ((state_d == S_FETCH) &&
        (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ}))
      retire_count_d = retire_count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_FETCH;
      wait_cnt_q     <= '0;
      retire_count_q <= '0;
      illegal_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      retire_count_q <= retire_count_d;
      illegal_q      <= illegal_d;
      timeout_q      <= timeout_d;
    end
  end

  mc_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

  assign imm_src       = imm_src_for(op);
  assign pc_write      = pc_write_c  & ~rst;
  assign mem_write     = mem_write_c & ~rst;
  assign ir_write      = ir_write_c  & ~rst;
  assign reg_write     = reg_write_c & ~rst;
  assign illegal_instr = illegal_q;
  assign mem_timeout   = timeout_q;
  assign retire_count  = retire_count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - table-driven and directed checks of multicycle_controller
module tb_multicycle_controller;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, S = 7'b0100011;
  localparam logic [6:0] L = 7'b0000011, B = 7'b1100011, J = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic        clk, rst, funct7b5, zero, mem_ready;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write;
  logic        illegal_instr, mem_timeout;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [31:0] retire_count;

  int n_cmp = 0;
  int n_fail = 0;

  multicycle_controller #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .reg_write(reg_write),
    .illegal_instr(illegal_instr), .mem_timeout(mem_timeout),
    .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        rdy;
    logic [17:0] exp;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl[$];

  // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, imm_src, alu_control, reg_write, illegal, timeout}
  function automatic logic [17:0] outs();
    return {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
            imm_src, alu_control, reg_write, illegal_instr, mem_timeout};
  endfunction

  function automatic vec_t v(input int r, input logic [6:0] o, input int f3, input int f7,
                             input int z, input int rdy, input int pcw, input int adr,
                             input int mw, input int irw, input int res, input int sa,
                             input int sb, input int imm, input int alu, input int rw,
                             input int ret);
    vec_t t;
    t.rst = r[0]; t.op = o; t.f3 = f3[2:0]; t.f7 = f7[0]; t.z = z[0]; t.rdy = rdy[0];
    t.exp = {pcw[0], adr[0], mw[0], irw[0], res[1:0], sa[1:0], sb[1:0], imm[1:0],
             alu[2:0], rw[0], 1'b0, 1'b0};
    t.ret = ret;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic rdy);
    rst = r; op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, R, 3'd0, 1'b0, 1'b0, 1'b0);
    adv();
  endtask

  initial begin
    rst = 1'b1; op = R; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    adv();
    adv();

    // reset cycle
    tbl.push_back(v(1,R,0,0,0,1, 0,0,0,0, 2,0,2,0,0, 0, 0));
    // add
    tbl.push_back(v(0,R,0,0,0,1, 1,0,0,1, 2,0,2,0,0, 0, 0));
    tbl.push_back(v(0,R,0,0,0,1, 0,0,0,0, 0,1,1,0,0, 0, 0));
    tbl.push_back(v(0,R,0,0,0,1, 0,0,0,0, 0,2,0,0,0, 0, 0));
    tbl.push_back(v(0,R,0,0,0,1, 0,0,0,0, 0,0,0,0,0, 1, 0));
    // sub
    tbl.push_back(v(0,R,0,1,0,1, 1,0,0,1, 2,0,2,0,0, 0, 1));
    tbl.push_back(v(0,R,0,1,0,1, 0,0,0,0, 0,1,1,0,0, 0, 1));
    tbl.push_back(v(0,R,0,1,0,1, 0,0,0,0, 0,2,0,0,1, 0, 1));
    tbl.push_back(v(0,R,0,1,0,1, 0,0,0,0, 0,0,0,0,0, 1, 1));
    // andi
    tbl.push_back(v(0,I,7,1,0,1, 1,0,0,1, 2,0,2,0,0, 0, 2));
    tbl.push_back(v(0,I,7,1,0,1, 0,0,0,0, 0,1,1,0,0, 0, 2));
    tbl.push_back(v(0,I,7,1,0,1, 0,0,0,0, 0,2,1,0,2, 0, 2));
    tbl.push_back(v(0,I,7,1,0,1, 0,0,0,0, 0,0,0,0,0, 1, 2));
    // addi with instr[30] set: still add
    tbl.push_back(v(0,I,0,1,0,1, 1,0,0,1, 2,0,2,0,0, 0, 3));
    tbl.push_back(v(0,I,0,1,0,1, 0,0,0,0, 0,1,1,0,0, 0, 3));
    tbl.push_back(v(0,I,0,1,0,1, 0,0,0,0, 0,2,1,0,0, 0, 3));
    tbl.push_back(v(0,I,0,1,0,1, 0,0,0,0, 0,0,0,0,0, 1, 3));
    // slt
    tbl.push_back(v(0,R,2,0,0,1, 1,0,0,1, 2,0,2,0,0, 0, 4));
    tbl.push_back(v(0,R,2,0,0,1, 0,0,0,0, 0,1,1,0,0, 0, 4));
    tbl.push_back(v(0,R,2,0,0,1, 0,0,0,0, 0,2,0,0,5, 0, 4));
    tbl.push_back(v(0,R,2,0,0,1, 0,0,0,0, 0,0,0,0,0, 1, 4));
    // sw
    tbl.push_back(v(0,S,2,0,0,1, 1,0,0,1, 2,0,2,1,0, 0, 5));
    tbl.push_back(v(0,S,2,0,0,1, 0,0,0,0, 0,1,1,1,0, 0, 5));
    tbl.push_back(v(0,S,2,0,0,1, 0,0,0,0, 0,2,1,1,0, 0, 5));
    tbl.push_back(v(0,S,2,0,0,1, 0,1,1,0, 0,0,0,1,0, 0, 5));
    // jal
    tbl.push_back(v(0,J,0,0,0,1, 1,0,0,1, 2,0,2,3,0, 0, 6));
    tbl.push_back(v(0,J,0,0,0,1, 0,0,0,0, 0,1,1,3,0, 0, 6));
    tbl.push_back(v(0,J,0,0,0,1, 1,0,0,0, 0,1,2,3,0, 0, 6));
    tbl.push_back(v(0,J,0,0,0,1, 0,0,0,0, 0,0,0,3,0, 1, 6));
    // beq taken
    tbl.push_back(v(0,B,0,0,1,1, 1,0,0,1, 2,0,2,2,0, 0, 7));
    tbl.push_back(v(0,B,0,0,1,1, 0,0,0,0, 0,1,1,2,0, 0, 7));
    tbl.push_back(v(0,B,0,0,1,1, 1,0,0,0, 0,2,0,2,1, 0, 7));
    // beq not taken
    tbl.push_back(v(0,B,0,0,0,1, 1,0,0,1, 2,0,2,2,0, 0, 8));
    tbl.push_back(v(0,B,0,0,0,1, 0,0,0,0, 0,1,1,2,0, 0, 8));
    tbl.push_back(v(0,B,0,0,0,1, 0,0,0,0, 0,2,0,2,1, 0, 8));
    // lw with one fetch wait and three MEMREAD waits
    tbl.push_back(v(0,L,2,0,0,0, 0,0,0,0, 2,0,2,0,0, 0, 9));
    tbl.push_back(v(0,L,2,0,0,1, 1,0,0,1, 2,0,2,0,0, 0, 9));
    tbl.push_back(v(0,L,2,0,0,1, 0,0,0,0, 0,1,1,0,0, 0, 9));
    tbl.push_back(v(0,L,2,0,0,1, 0,0,0,0, 0,2,1,0,0, 0, 9));
    tbl.push_back(v(0,L,2,0,0,0, 0,1,0,0, 0,0,0,0,0, 0, 9));
    tbl.push_back(v(0,L,2,0,0,0, 0,1,0,0, 0,0,0,0,0, 0, 9));
    tbl.push_back(v(0,L,2,0,0,0, 0,1,0,0, 0,0,0,0,0, 0, 9));
    tbl.push_back(v(0,L,2,0,0,1, 0,1,0,0, 0,0,0,0,0, 0, 9));
    tbl.push_back(v(0,L,2,0,0,1, 0,0,0,0, 1,0,0,0,0, 1, 9));
    tbl.push_back(v(0,R,0,0,0,0, 0,0,0,0, 2,0,2,0,0, 0, 10));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].rdy);
      chk($sformatf("row%0d_outs", i), 32'(outs()), 32'(tbl[i].exp));
      chk($sformatf("row%0d_retire", i), retire_count, tbl[i].ret);
      adv();
    end

    // reset during a MEMWRITE wait abandons the store and clears the retire count
    cyc(1'b0, S, 3'd2, 1'b0, 1'b0, 1'b1); adv();
    cyc(1'b0, S, 3'd2, 1'b0, 1'b0, 1'b1); adv();
    cyc(1'b0, S, 3'd2, 1'b0, 1'b0, 1'b1); adv();
    cyc(1'b0, S, 3'd2, 1'b0, 1'b0, 1'b0);
    chk("sw_wait_mem_write", 32'(mem_write), 32'd1);
    adv();
    cyc(1'b1, S, 3'd2, 1'b0, 1'b0, 1'b0);
    chk("sw_rst_mem_write", 32'(mem_write), 32'd0);
    adv();
    cyc(1'b0, S, 3'd2, 1'b0, 1'b0, 1'b0);
    chk("sw_rst_fetch_srcb", 32'(alu_src_b), 32'd2);
    chk("sw_rst_retire", retire_count, 32'd0);
    adv();

    // fetch timeout after 16 cycles of mem_ready=0
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, R, 3'd0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("to_wait%0d", i), 32'(mem_timeout), 32'd0);
      adv();
    end
    cyc(1'b0, R, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("to_flag", 32'(mem_timeout), 32'd1);
    chk("to_trap_outs", 32'({result_src, alu_src_b, ir_write, pc_write}), 32'd0);
    chk("to_no_illegal", 32'(illegal_instr), 32'd0);
    adv();

    // mem_ready arriving on the 16th cycle wins over the timeout
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b0, R, 3'd0, 1'b0, 1'b0, 1'b0);
      adv();
    end
    cyc(1'b0, R, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("nto_ir_write", 32'(ir_write), 32'd1);
    adv();
    cyc(1'b0, R, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("nto_decode_srca", 32'(alu_src_a), 32'd1);
    chk("nto_flag", 32'(mem_timeout), 32'd0);
    adv();

    // illegal opcode traps until reset
    do_reset();
    cyc(1'b0, BAD, 3'd0, 1'b0, 1'b0, 1'b1); adv();
    cyc(1'b0, BAD, 3'd0, 1'b0, 1'b0, 1'b1); adv();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, BAD, 3'd0, 1'b0, 1'b1, 1'b1);
      chk($sformatf("ill_flag%0d", i), 32'(illegal_instr), 32'd1);
      chk($sformatf("ill_en%0d", i), 32'({pc_write, ir_write, mem_write, reg_write}), 32'd0);
      adv();
    end
    do_reset();
    cyc(1'b0, R, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("ill_cleared", 32'(illegal_instr), 32'd0);
    chk("ill_fetch_srcb", 32'(alu_src_b), 32'd2);
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
